// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index, queued writeback
// entry and the result of a bypass lookup.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t rd;
    word_t    data;
  } wb_entry_t;

  typedef struct packed {
    logic  hit;
    word_t data;
  } lookup_t;

endpackage

// File: rtl/writeback_queue.sv
// Writeback queue: merges load and ALU results into a single register-file
// write port, with a youngest-match bypass search over the queued entries.
module writeback_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     mem_valid,
  input  regbits_t mem_rd,
  input  word_t    mem_data,
  output logic     mem_ready,
  input  logic     alu_valid,
  input  regbits_t alu_rd,
  input  word_t    alu_data,
  output logic     alu_ready,
  output logic     wb_wen,
  output regbits_t wb_wsel,
  output word_t    wb_wdat,
  input  regbits_t lk_sel1,
  input  regbits_t lk_sel2,
  output logic     lk_hit1,
  output logic     lk_hit2,
  output word_t    lk_dat1,
  output word_t    lk_dat2
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  wb_entry_t [DEPTH-1:0] entries_q;
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic memStore;
  logic aluStore;
  logic deqEn;
  ptr_t aluIdx;
  wb_entry_t headEntry;
  lookup_t lk1;
  lookup_t lk2;

  // Ready looks only at registered occupancy; the ALU port needs two free
  // slots so that both ports can fire in the same cycle without overflow.
  assign mem_ready = (count_q < cnt_t'(DEPTH));
  assign alu_ready = (count_q <= cnt_t'(DEPTH - 2));

  assign memStore = mem_valid && mem_ready && (mem_rd != '0);
  assign aluStore = alu_valid && alu_ready && (alu_rd != '0);
  assign deqEn    = (count_q != '0);
  assign aluIdx   = tail_q + ptr_t'(memStore);

  always_comb begin
    head_d  = head_q + ptr_t'(deqEn);
    tail_d  = tail_q + ptr_t'(memStore) + ptr_t'(aluStore);
    count_d = count_q + cnt_t'(memStore) + cnt_t'(aluStore) - cnt_t'(deqEn);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: only slots counted by count_q are ever read.
  always_ff @(posedge CLK) begin
    if (memStore) entries_q[tail_q] <= wb_entry_t'{rd: mem_rd, data: mem_data};
    if (aluStore) entries_q[aluIdx] <= wb_entry_t'{rd: alu_rd, data: alu_data};
  end

  assign headEntry = entries_q[head_q];

  always_comb begin
    wb_wen  = deqEn;
    wb_wsel = deqEn ? headEntry.rd   : '0;
    wb_wdat = deqEn ? headEntry.data : '0;
  end

  function automatic lookup_t findYoungest(input wb_entry_t [DEPTH-1:0] ents,
                                           input ptr_t head,
                                           input cnt_t count,
                                           input regbits_t sel);
    lookup_t res;
    logic    found;
    ptr_t    idx;
    res   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = head + ptr_t'(i);
      if (!found && (sel != '0) && (cnt_t'(i) < count) && (ents[idx].rd == sel)) begin
        found    = 1'b1;
        res.hit  = 1'b1;
        res.data = ents[idx].data;
      end
    end
    return res;
  endfunction

  always_comb begin
    lk1     = findYoungest(entries_q, head_q, count_q, lk_sel1);
    lk2     = findYoungest(entries_q, head_q, count_q, lk_sel2);
    lk_hit1 = lk1.hit;
    lk_dat1 = lk1.data;
    lk_hit2 = lk2.hit;
    lk_dat2 = lk2.data;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: the driver pushes accepted results
// into an in-order queue, a negedge monitor pops and compares every retire.
module tb_writeback_queue;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;

  logic     CLK = 1'b0;
  logic     RST = 1'b1;
  logic     mem_valid = 1'b0;
  regbits_t mem_rd = '0;
  word_t    mem_data = '0;
  logic     mem_ready;
  logic     alu_valid = 1'b0;
  regbits_t alu_rd = '0;
  word_t    alu_data = '0;
  logic     alu_ready;
  logic     wb_wen;
  regbits_t wb_wsel;
  word_t    wb_wdat;
  regbits_t lk_sel1 = '0;
  regbits_t lk_sel2 = '0;
  logic     lk_hit1, lk_hit2;
  word_t    lk_dat1, lk_dat2;

  int checks = 0;
  int errors = 0;
  bit monitorOn = 1'b0;

  // Results the register file must still receive, oldest first.
  wb_entry_t sbQ[$];

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .lk_sel1(lk_sel1), .lk_sel2(lk_sel2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_dat1(lk_dat1), .lk_dat2(lk_dat2)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelLookup(input regbits_t sel, output logic hit, output word_t dat);
    hit = 1'b0;
    dat = '0;
    if (sel != '0) begin
      for (int i = sbQ.size() - 1; i >= 0; i--) begin
        if (sbQ[i].rd == sel) begin
          hit = 1'b1;
          dat = sbQ[i].data;
          break;
        end
      end
    end
  endfunction

  // Drives one cycle starting just after a posedge; records accepted results.
  task automatic applyStimulus(input logic mv, input regbits_t mrd, input word_t md,
                               input logic av, input regbits_t ard, input word_t ad,
                               output logic memAcc, output logic aluAcc);
    logic memRdy, aluRdy;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    memRdy = mem_ready;
    aluRdy = alu_ready;
    @(posedge CLK);
    memAcc = mv && memRdy;
    aluAcc = av && aluRdy;
    if (memAcc && mrd != '0) sbQ.push_back(wb_entry_t'{rd: mrd, data: md});
    if (aluAcc && ard != '0) sbQ.push_back(wb_entry_t'{rd: ard, data: ad});
    #1;
  endtask

  task automatic idleCycle();
    logic ma, aa;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, ma, aa);
  endtask

  task automatic doReset();
    RST = 1'b1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("rstWen", 32'(wb_wen), 32'd0);
    checkOutput("rstMemReady", 32'(mem_ready), 32'd1);
    checkOutput("rstAluReady", 32'(alu_ready), 32'd1);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Monitor: sees the queue state that the DUT holds during this cycle.
  initial begin : monitor
    wb_entry_t exp;
    logic eh;
    word_t ed;
    forever begin
      @(negedge CLK);
      if (monitorOn) begin
        checkOutput("memReady", 32'(mem_ready), 32'(sbQ.size() < DEPTH));
        checkOutput("aluReady", 32'(alu_ready), 32'(sbQ.size() <= DEPTH - 2));
        modelLookup(lk_sel1, eh, ed);
        checkOutput("lkHit1", 32'(lk_hit1), 32'(eh));
        checkOutput("lkDat1", lk_dat1, ed);
        modelLookup(lk_sel2, eh, ed);
        checkOutput("lkHit2", 32'(lk_hit2), 32'(eh));
        checkOutput("lkDat2", lk_dat2, ed);
        if (sbQ.size() > 0) begin
          exp = sbQ.pop_front();
          checkOutput("wbWen", 32'(wb_wen), 32'd1);
          checkOutput("wbWsel", 32'(wb_wsel), 32'(exp.rd));
          checkOutput("wbWdat", wb_wdat, exp.data);
        end else begin
          checkOutput("wbWenIdle", 32'(wb_wen), 32'd0);
          checkOutput("wbWselIdle", 32'(wb_wsel), 32'd0);
          checkOutput("wbWdatIdle", wb_wdat, 32'd0);
        end
      end
    end
  end

  initial begin : driver
    logic ma, aa;
    logic memPend, aluPend;
    logic mv, av;
    regbits_t mrd, ard;
    word_t md, ad;
    bit sawAluLow;
    int seq;
    int drain;

    monitorOn = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    checkOutput("resetWen", 32'(wb_wen), 32'd0);
    checkOutput("resetLk1", 32'(lk_hit1), 32'd0);

    // Single load, one-cycle latency.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, ma, aa);
    mem_valid = 1'b0;
    #1;
    checkOutput("loadWen", 32'(wb_wen), 32'd1);
    checkOutput("loadWsel", 32'(wb_wsel), 32'd5);
    checkOutput("loadWdat", wb_wdat, 32'hDEADBEEF);
    idleCycle();
    checkOutput("loadDone", 32'(wb_wen), 32'd0);

    // Both ports in one cycle: load retires first.
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, ma, aa);
    checkOutput("dualFirst", 32'(wb_wsel), 32'd3);
    idleCycle();
    checkOutput("dualSecond", 32'(wb_wsel), 32'd4);
    checkOutput("dualSecondDat", wb_wdat, 32'h22);
    idleCycle();

    // rd = 0 is accepted but never stored.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, ma, aa);
    checkOutput("r0Acc", 32'(aa), 32'd1);
    checkOutput("r0Wen", 32'(wb_wen), 32'd0);
    checkOutput("r0AluReady", 32'(alu_ready), 32'd1);
    idleCycle();

    // Youngest-match bypass.
    lk_sel2 = '0;
    applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, ma, aa);
    lk_sel1 = 5'd7;
    #1;
    checkOutput("bypHit", 32'(lk_hit1), 32'd1);
    checkOutput("bypDat", lk_dat1, 32'hB);
    idleCycle();
    idleCycle();
    checkOutput("bypGoneHit", 32'(lk_hit1), 32'd0);
    checkOutput("bypGoneDat", lk_dat1, 32'd0);

    // Sustained dual input with holding producers, across pointer wrap.
    memPend = 1'b0; aluPend = 1'b0; sawAluLow = 1'b0; seq = 0;
    mrd = '0; ard = '0; md = '0; ad = '0;
    for (int c = 0; c < 24; c++) begin
      if (!memPend) begin seq++; mrd = regbits_t'(seq % 31 + 1); md = $urandom; end
      if (!aluPend) begin seq++; ard = regbits_t'(seq % 31 + 1); ad = $urandom; end
      if (!alu_ready) sawAluLow = 1'b1;
      applyStimulus(1'b1, mrd, md, 1'b1, ard, ad, ma, aa);
      memPend = !ma;
      aluPend = !aa;
    end
    checkOutput("aluReadyDropped", 32'(sawAluLow), 32'd1);
    repeat (4) idleCycle();

    // Reset with three entries queued.
    applyStimulus(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, ma, aa);
    applyStimulus(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, ma, aa);
    checkOutput("preRstCount", 32'(sbQ.size()), 32'd3);
    doReset();
    idleCycle();
    checkOutput("postRstWen", 32'(wb_wen), 32'd0);

    // Randomised traffic with producer hold, plus one mid-burst reset.
    memPend = 1'b0; aluPend = 1'b0;
    mv = 1'b0; av = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        doReset();
        memPend = 1'b0; aluPend = 1'b0;
      end
      if (!memPend) begin
        mv = ($urandom_range(0, 99) < 60); mrd = regbits_t'($urandom_range(0, 7)); md = $urandom;
      end
      if (!aluPend) begin
        av = ($urandom_range(0, 99) < 60); ard = regbits_t'($urandom_range(0, 7)); ad = $urandom;
      end
      lk_sel1 = regbits_t'($urandom_range(0, 7));
      lk_sel2 = regbits_t'($urandom_range(0, 7));
      applyStimulus(mv, mrd, md, av, ard, ad, ma, aa);
      memPend = mv && !ma;
      aluPend = av && !aa;
    end

    drain = 0;
    while (sbQ.size() > 0 && drain < 20) begin
      idleCycle();
      drain++;
    end
    checkOutput("drainEmpty", 32'(sbQ.size()), 32'd0);
    idleCycle();
    monitorOn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers completed results from the execute (ALU) and memory (load) paths and retires them into the register file write port, one write per cycle. Sits between the pipeline's producer stages and the register file write interface (enable, 5-bit select, 32-bit data). Provides a youngest-match bypass lookup so decode can read results that are still queued.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- mem_valid  in  1  load result offered
- mem_rd  in  5  load destination register
- mem_data  in  32  load result
- mem_ready  out  1  load port may enqueue
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU port may enqueue
- wb_wen  out  1  register file write enable
- wb_wsel  out  5  register file write select
- wb_wdat  out  32  register file write data
- lk_sel1, lk_sel2  in  5 each  bypass lookup register numbers
- lk_hit1, lk_hit2  out  1 each  queued value exists for lookup register
- lk_dat1, lk_dat2  out  32 each  youngest queued value for lookup register

## Operation
- Circular buffer of DEPTH entries {rd, data}; head/tail pointers of log2(DEPTH) bits wrap naturally; separate count of log2(DEPTH)+1 bits.
- free = DEPTH − count, from registered count only; ready never depends on valid or on the same-cycle dequeue.
- mem_ready = (free ≥ 1); alu_ready = (free ≥ 2). Guarantees both ports can fire together without overflow.
- Handshake: transfer when valid && ready at posedge. Producer holds rd/data stable while valid && !ready.
- Same-cycle double enqueue: memory entry written at tail, ALU entry at tail+1 (load is the older instruction).
- Transfer with rd = 0: handshake completes, nothing stored, no slot consumed. With both ports firing and one rd = 0, the surviving entry goes to tail.
- Dequeue: whenever count ≠ 0, wb_wen = 1, wb_wsel/wb_wdat = head entry; head advances and count decrements at next posedge. The register file captures on the following negedge, within the same cycle.
- Empty: wb_wen = 0, wb_wsel = 0, wb_wdat = 0.
- count_next = count + enqueued − dequeued; simultaneous enqueue and dequeue while full is impossible because ready is computed from the registered count.
- Lookup: combinational search of all occupied entries, including the head being written. The youngest entry (closest to tail) with rd == lk_sel wins. lk_sel = 0 always returns hit = 0, dat = 0. On a miss, dat = 0.
- Reset (any time, including mid-burst): head = tail = count = 0, queued contents discarded. Outputs: wb_wen 0, wb_wsel 0, wb_wdat 0, mem_ready 1, alu_ready 1, lk_hit* 0, lk_dat* 0.

## Timing
- Enqueue→write latency: 1 cycle when queue empty (accepted at posedge N, wb_wen high during cycle N+1).
- Throughput: 1 retire per cycle; sustained input of 2/cycle fills the queue, then alu_ready drops.
- Lookup and ready paths are combinational from registered state; no input-to-output combinational path except lk_sel→lk_hit/lk_dat.
- Reset deassertion: first enqueue possible at the first posedge after RST falls.

## Structure
- Add wb_entry_t (packed: regbits_t rd; word_t data) to cpu_types_pkg. Use the existing word_t and regbits_t from that package.
- Search written as a function (youngest-first scan) instantiated twice. No sub-module is natural; single module.

## Test plan
- Reset, single load mem_rd = 5, data = 0xDEADBEEF → next cycle wb_wen = 1, wsel = 5, wdat = 0xDEADBEEF; cycle after, wb_wen = 0.
- Both ports same cycle (mem rd 3 = 0x11, alu rd 4 = 0x22) → writes rd 3 then rd 4 on consecutive cycles.
- Enqueue with rd = 0 on ALU (data 0xFFFF) → no write ever; count unchanged; mem_ready/alu_ready stay 1.
- Hold both valid continuously with DEPTH = 4 → alu_ready drops at count 3 and mem_ready at count 4. No entry lost or duplicated; writes in acceptance order across pointer wrap.
- Queue rd 7 = 0xA then rd 7 = 0xB, lookup lk_sel1 = 7 → hit = 1, dat = 0xB. After both retire → hit = 0, dat = 0. lk_sel2 = 0 → hit = 0 throughout.
- Assert RST with 3 entries queued → wb_wen = 0 immediately (async), both ready = 1; after release, no stale entry is written.
